// File: rtl/core_pkg.sv
// Shared core types for the register writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_index_t;
  typedef logic [CORE_XLEN-1:0] word_t;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_source_e;

  // x0 is hardwired; writes to it are consumed but never strobed.
  localparam reg_index_t REG_ZERO = '0;

endpackage

// File: rtl/writeback_arbiter_slot.sv
// wb_slot: one-entry holding buffer between a result source and the arbiter.
// Latency: entry visible (empty=0) the cycle after the accepting edge.
// Backpressure: in_rdy = empty OR granted this cycle; a full, ungranted slot stalls the source.
// Ports: clk/rst; in_vld/in_rdy/in_dest/in_dat from the source;
//        grant from the arbiter; empty/dest/dat describe the held entry.
module wb_slot
  import core_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [REG_IDX_W-1:0] in_dest,
  input  logic [W-1:0]     in_dat,
  input  logic             grant,
  output logic             empty,
  output logic [REG_IDX_W-1:0] dest,
  output logic [W-1:0]     dat
);

  logic       full_q, full_d;
  reg_index_t dest_q, dest_d;
  logic [W-1:0] dat_q, dat_d;

  // Refill in the same cycle the held entry leaves, so a source can
  // sustain one result per cycle while it keeps winning.
  assign in_rdy = !full_q || grant;

  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    dat_d  = dat_q;
    if (grant) begin
      full_d = 1'b0;
    end
    if (in_vld && in_rdy) begin
      full_d = 1'b1;
      dest_d = in_dest;
      dat_d  = in_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      dest_q <= '0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      dat_q  <= dat_d;
    end
  end

  assign empty = !full_q;
  assign dest  = dest_q;
  assign dat   = dat_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into the single register-file write port.
// Latency: accepted at edge E -> write strobe in the cycle after E+1; loser of a tie waits one more cycle.
// Backpressure: per-source valid/ready via a one-entry slot; ready drops only while the slot is full and not granted.
// Ports: i_Clock/i_Reset; ALU and load valid/ready/dest/data inputs;
//        o_WriteEnable/o_RegDest/o_DataOut register-file port; o_PendingMask for decode hazard stalls.
module writeback_arbiter
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_AluValid,
  output logic                 o_AluReady,
  input  logic [REG_IDX_W-1:0] i_AluRegDest,
  input  logic [XLEN-1:0]      i_AluData,
  input  logic                 i_LoadValid,
  output logic                 o_LoadReady,
  input  logic [REG_IDX_W-1:0] i_LoadRegDest,
  input  logic [XLEN-1:0]      i_LoadData,
  output logic                 o_WriteEnable,
  output logic [REG_IDX_W-1:0] o_RegDest,
  output logic [XLEN-1:0]      o_DataOut,
  output logic [NUM_REGS-1:0]  o_PendingMask
);

  logic            alu_empty, load_empty;
  logic            alu_grant, load_grant;
  reg_index_t      alu_dest, load_dest;
  logic [XLEN-1:0] alu_dat, load_dat;

  wb_source_e      last_grant_q, last_grant_d;
  logic            we_q, we_d;
  reg_index_t      reg_dest_q, reg_dest_d;
  logic [XLEN-1:0] data_q, data_d;

  wb_slot #(.W(XLEN)) u_alu_slot (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .in_vld  (i_AluValid),
    .in_rdy  (o_AluReady),
    .in_dest (i_AluRegDest),
    .in_dat  (i_AluData),
    .grant   (alu_grant),
    .empty   (alu_empty),
    .dest    (alu_dest),
    .dat     (alu_dat)
  );

  wb_slot #(.W(XLEN)) u_load_slot (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .in_vld  (i_LoadValid),
    .in_rdy  (o_LoadReady),
    .in_dest (i_LoadRegDest),
    .in_dat  (i_LoadData),
    .grant   (load_grant),
    .empty   (load_empty),
    .dest    (load_dest),
    .dat     (load_dat)
  );

  // Round-robin over occupied slots; on a tie the source not granted last wins.
  always_comb begin
    alu_grant  = 1'b0;
    load_grant = 1'b0;
    if (!alu_empty && !load_empty) begin
      if (last_grant_q == WB_LOAD) alu_grant  = 1'b1;
      else                         load_grant = 1'b1;
    end else if (!alu_empty) begin
      alu_grant = 1'b1;
    end else if (!load_empty) begin
      load_grant = 1'b1;
    end
  end

  // Output register: dest/data hold when idle; x0 entries consume a grant but never strobe.
  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    reg_dest_d   = reg_dest_q;
    data_d       = data_q;
    if (alu_grant) begin
      last_grant_d = WB_ALU;
      reg_dest_d   = alu_dest;
      data_d       = alu_dat;
      we_d         = (alu_dest != REG_ZERO);
    end else if (load_grant) begin
      last_grant_d = WB_LOAD;
      reg_dest_d   = load_dest;
      data_d       = load_dat;
      we_d         = (load_dest != REG_ZERO);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      last_grant_q <= WB_LOAD;
      we_q         <= 1'b0;
      reg_dest_q   <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      reg_dest_q   <= reg_dest_d;
      data_q       <= data_d;
    end
  end

  // Pending mask from registered state only, so decode sees no combinational path from the sources.
  always_comb begin
    o_PendingMask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      o_PendingMask[r] = (!alu_empty  && (alu_dest   == REG_IDX_W'(r))) ||
                         (!load_empty && (load_dest  == REG_IDX_W'(r))) ||
                         (we_q        && (reg_dest_q == REG_IDX_W'(r)));
    end
  end

  assign o_WriteEnable = we_q;
  assign o_RegDest     = reg_dest_q;
  assign o_DataOut     = data_q;

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges register writeback traffic from the ALU and load unit into the single write port of the integer register file. Each source gets a one-entry holding slot behind a valid/ready handshake. A round-robin arbiter drains the slots into a registered write port. A pending-destination mask feeds decode hazard stalls.

## Interface
- XLEN, 32, data width of results and register file write data
- NUM_REGS, 32, architectural register count; index width is $clog2(NUM_REGS)

Ports:
- i_Clock  in  1  core clock
- i_Reset  in  1  asynchronous, active-high reset
- i_AluValid  in  1  ALU result offered
- o_AluReady  out  1  ALU slot can accept
- i_AluRegDest  in  5  ALU destination index
- i_AluData  in  XLEN  ALU result
- i_LoadValid  in  1  load result offered
- o_LoadReady  out  1  load slot can accept
- i_LoadRegDest  in  5  load destination index
- i_LoadData  in  XLEN  load result
- o_WriteEnable  out  1  register file write strobe
- o_RegDest  out  5  register file destination index
- o_DataOut  out  XLEN  register file write data
- o_PendingMask  out  NUM_REGS  bit d set while a write to x<d> is buffered or on the output port

## Operation
- Handshake per source: transfer when valid && ready at a rising edge. Valid must not depend on ready.
- Ready = slot empty OR slot granted this cycle, so each source can sustain one result per cycle.
- Arbitration, combinational on occupied slots:
  - one occupied: grant it;
  - both occupied: grant the source not granted last;
  - none: no grant.
- r_LastGrant updates only on a grant. Reset value = LOAD, so the ALU wins the first tie.
- Granted slot loads the output register at the next edge: o_RegDest/o_DataOut = slot contents; o_WriteEnable = 1 unless dest == 0.
- With no grant, o_WriteEnable = 0; o_RegDest and o_DataOut hold their values.
- Dest x0 entries are accepted and consume a grant, but produce no write strobe.
- o_PendingMask = OR of one-hot(dest) over occupied slots, plus one-hot(o_RegDest) when o_WriteEnable is set. Bit 0 is forced to 0. Combinational from registered state only.
- Same dest in both slots: both writes are issued in grant order. Program order across sources is the issue logic's job (it stalls on o_PendingMask).

## Timing
- Latency: accepted at edge E → o_WriteEnable high during the cycle after edge E+1 (no contention) → register file updated at edge E+2.
- Under contention the loser waits exactly one extra cycle. Round-robin bounds any wait to 1 grant.
- Throughput: one write per cycle total.
- Reset (asynchronous, any time):
  - slots empty; o_WriteEnable = 0; o_RegDest = 0; o_DataOut = 0; o_PendingMask = 0;
  - both readies = 1 once reset deasserts;
  - in-flight entries are discarded, with no partial write.
- Slot full, not granted, valid high: ready = 0, source holds its data. No loss and no duplication.
- Simultaneous accept into an empty slot and grant of the other slot is legal in the same cycle.

## Structure
- Shared package core_pkg:
  - reg_index_t (5-bit);
  - word_t (XLEN);
  - wb_source_e {WB_ALU, WB_LOAD};
  - REG_ZERO constant.
- Sub-module wb_slot: one-entry buffer with valid/ready in, grant/empty out. Instantiated twice.
- Arbiter, output register and mask generation live in the top module.

## Test plan
- Single ALU write: ALU valid, dest 5, data 0xDEADBEEF → o_WriteEnable=1, o_RegDest=5, o_DataOut=0xDEADBEEF two edges after acceptance; o_PendingMask[5]=1 from acceptance until the strobe cycle ends.
- Contention: both valid every cycle, ALU dest 1..4, load dest 11..14 → outputs alternate 1,11,2,12,…; each ready toggles so throughput is 1/cycle total; no drops.
- x0 drop: load dest 0, data 0x1 → no o_WriteEnable pulse; o_PendingMask stays 0; load slot frees next cycle.
- Back-pressure: fill both slots, hold valids with new data → readies stay 0 until granted; every offered value appears exactly once.
- Reset mid-flight: assert i_Reset asynchronously with both slots full and the output strobing → all outputs 0 immediately; after release, readies = 1 and the next ALU entry wins the first tie.
